// File: rtl/dmem_master.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_master
//  Description : Memory-stage initiator for a word-addressed single-port data
//                RAM. Handles MIPS LB/LBU/LH/LHU/LW/SB/SH/SW. Sub-word stores
//                use a two-cycle read-modify-write because the RAM has no byte
//                enables.
//  Options     : DMEM_MISALIGN_TRAP_EN - when defined, misaligned accesses are
//                trapped (misalign pulse, no RAM access). When undefined, the
//                offending low address bits are forced to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_master #(
    parameter int RAM_AW  = 17,
    parameter bit BIG_END = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [2:0]        mem_op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              stall_req,
    output logic              misalign,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RMW_WR = 1'b1;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    logic [0:0]        state_q, state_d;
    logic [31:0]       merge_q, merge_d;
    logic [RAM_AW-1:0] waddr_q, waddr_d;

    logic        is_byte, is_half, is_word, is_sub_store, trap;
    logic [1:0]  off;
    logic [4:0]  shamt;
    logic [31:0] lane, load_data, lane_mask, ins_data, merged;
    logic        addr_unused;

    // Upper address bits are deliberately ignored: accesses wrap modulo RAM size.
    assign addr_unused = &{1'b0, addr[31:RAM_AW+2]};

    assign is_byte      = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
    assign is_half      = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
    assign is_word      = (mem_op == OP_LW) || (mem_op == OP_SW);
    assign is_sub_store = (mem_op == OP_SB) || (mem_op == OP_SH);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Lane offset with misaligned low bits forced to zero, then the bit shift
    // that moves the addressed lane down to bit 0 for the selected endianness.
    always_comb begin
        off = is_byte ? addr[1:0] : (is_half ? {addr[1], 1'b0} : 2'b00);
        if (BIG_END) begin
            shamt = is_byte ? {~off, 3'b000} : (is_half ? {~off[1], 4'b0000} : 5'd0);
        end else begin
            shamt = is_byte ? {off, 3'b000} : (is_half ? {off[1], 4'b0000} : 5'd0);
        end
    end

    // Load extraction / extension and store-lane merge
    always_comb begin
        lane = ram_rdata >> shamt;
        case (mem_op)
            OP_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  load_data = {24'h0, lane[7:0]};
            OP_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  load_data = {16'h0, lane[15:0]};
            default: load_data = ram_rdata;
        endcase
        lane_mask = (is_byte ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
        ins_data  = (wdata & (is_byte ? 32'h0000_00FF : 32'h0000_FFFF)) << shamt;
        merged    = (ram_rdata & ~lane_mask) | ins_data;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only an aligned sub-word store enters the write cycle
    always_comb begin
        state_d = ST_IDLE;
        if (state_q == ST_IDLE && req && is_sub_store && !trap) begin
            state_d = ST_RMW_WR;
        end
    end

    // Capture merged word and word index during the read cycle of a RMW
    always_comb begin
        merge_d = merge_q;
        waddr_d = waddr_q;
        if (state_q == ST_IDLE && state_d == ST_RMW_WR) begin
            merge_d = merged;
            waddr_d = addr[RAM_AW+1:2];
        end
    end

    // RMW data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            merge_q <= 32'h0;
            waddr_q <= '0;
        end else begin
            merge_q <= merge_d;
            waddr_q <= waddr_d;
        end
    end

    // Output logic; everything is forced low while rst is asserted
    always_comb begin
        rdata     = 32'h0;
        done      = 1'b0;
        stall_req = 1'b0;
        misalign  = 1'b0;
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = 32'h0;
        if (!rst) begin
            if (state_q == ST_RMW_WR) begin
                ram_ce    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = waddr_q;
                ram_wdata = merge_q;
                done      = 1'b1;
            end else if (req) begin
                if (trap) begin
                    misalign = 1'b1;
                    done     = 1'b1;
                end else begin
                    ram_ce   = 1'b1;
                    ram_addr = addr[RAM_AW+1:2];
                    if (mem_op == OP_SW) begin
                        ram_we    = 1'b1;
                        ram_wdata = wdata;
                        done      = 1'b1;
                    end else if (is_sub_store) begin
                        stall_req = 1'b1;
                    end else begin
                        rdata = load_data;
                        done  = 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_master
//  Description : Scoreboard bench for dmem_master (BIG_END=1) with a
//                behavioural combinational-read RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_master;

    logic        clk, rst, req;
    logic [2:0]  mem_op;
    logic [31:0] addr, wdata, rdata, ram_wdata, ram_rdata;
    logic        done, stall_req, misalign, ram_ce, ram_we;
    logic [16:0] ram_addr;
    logic        init_mem;
    logic [31:0] mem [0:63];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        we;
        logic [31:0] wdata;
        logic        mis;
        logic        ce;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    dmem_master #(.RAM_AW(17), .BIG_END(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .mem_op(mem_op), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done(done), .stall_req(stall_req),
        .misalign(misalign), .ram_ce(ram_ce), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, synchronous write
    assign ram_rdata = (ram_addr < 17'd64) ? mem[ram_addr[5:0]] : 32'h0;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h1122_3344;
            mem[5] <= 32'h80F0_7F01;
        end else if (ram_ce && ram_we && ram_addr < 17'd64) begin
            mem[ram_addr[5:0]] <= ram_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: every completed request is matched against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_rdata"}, rdata, e.rdata);
                chk({e.name, "_ce"}, {31'b0, ram_ce}, {31'b0, e.ce});
                chk({e.name, "_we"}, {31'b0, ram_we}, {31'b0, e.we});
                chk({e.name, "_mis"}, {31'b0, misalign}, {31'b0, e.mis});
                chk({e.name, "_stall"}, {31'b0, stall_req}, 32'h0);
                if (e.we) chk({e.name, "_wdata"}, ram_wdata, e.wdata);
            end
        end
    end

    // Issue one request (called just after a rising edge); sub-word stores
    // are held for the extra cycle and their read cycle is checked here.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ewe, input logic [31:0] ewd,
                         input logic emis, input logic ece, input string nm);
        exp_t e;
        e.rdata = er; e.we = ewe; e.wdata = ewd; e.mis = emis; e.ce = ece; e.name = nm;
        sb_q.push_back(e);
        req = 1'b1; mem_op = op; addr = a; wdata = wd;
        if ((op == 3'd5 || op == 3'd6) && !emis) begin
            @(negedge clk);
            chk({nm, "_c0_stall"}, {31'b0, stall_req}, 32'h1);
            chk({nm, "_c0_we"}, {31'b0, ram_we}, 32'h0);
            chk({nm, "_c0_done"}, {31'b0, done}, 32'h0);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; init_mem = 1'b1;
        req = 1'b1; mem_op = 3'd4; addr = 32'h10; wdata = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ce", {31'b0, ram_ce}, 32'h0);
        chk("rst_we", {31'b0, ram_we}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; init_mem = 1'b0; req = 1'b0;
        @(negedge clk);
        chk("idle_ce", {31'b0, ram_ce}, 32'h0);
        chk("idle_stall", {31'b0, stall_req}, 32'h0);
        @(posedge clk); #1;

        // Loads against the initial image
        issue(3'd0, 32'h10, 0, 32'h0000_0011, 0, 0, 0, 1, "lb_10");
        issue(3'd0, 32'h13, 0, 32'h0000_0044, 0, 0, 0, 1, "lb_13");
        issue(3'd1, 32'h14, 0, 32'h0000_0080, 0, 0, 0, 1, "lbu_14");
        issue(3'd0, 32'h14, 0, 32'hFFFF_FF80, 0, 0, 0, 1, "lb_14");
        issue(3'd2, 32'h16, 0, 32'h0000_7F01, 0, 0, 0, 1, "lh_16");
        issue(3'd3, 32'h14, 0, 32'h0000_80F0, 0, 0, 0, 1, "lhu_14");
        issue(3'd4, 32'h14, 0, 32'h80F0_7F01, 0, 0, 0, 1, "lw_14");

        // Stores: SB then read-back, SH back-to-back with SW
        issue(3'd5, 32'h11, 32'h0000_00AB, 0, 1, 32'h11AB_3344, 0, 1, "sb_11");
        issue(3'd4, 32'h10, 0, 32'h11AB_3344, 0, 0, 0, 1, "lw_10_after_sb");
        issue(3'd6, 32'h12, 32'h0000_BEEF, 0, 1, 32'h11AB_BEEF, 0, 1, "sh_12");
        issue(3'd7, 32'h14, 32'hCAFE_F00D, 0, 1, 32'hCAFE_F00D, 0, 1, "sw_14");
        chk("mem4_after_sh", mem[4], 32'h11AB_BEEF);
        chk("mem5_after_sw", mem[5], 32'hCAFE_F00D);

        issue(3'd4, 32'h14, 0, 32'hCAFE_F00D, 0, 0, 0, 1, "lw_14_after_sw");
        issue(3'd2, 32'h10, 0, 32'h0000_11AB, 0, 0, 0, 1, "lh_10");
        issue(3'd0, 32'h12, 0, 32'hFFFF_FFBE, 0, 0, 0, 1, "lb_12");
        issue(3'd3, 32'h12, 0, 32'h0000_BEEF, 0, 0, 0, 1, "lhu_12");
        issue(3'd1, 32'h17, 0, 32'h0000_000D, 0, 0, 0, 1, "lbu_17");
        issue(3'd4, 32'h0008_0010, 0, 32'h11AB_BEEF, 0, 0, 0, 1, "lw_wrap");

        // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
        issue(3'd4, 32'h12, 0, 32'h0, 0, 0, 1, 0, "lw_mis_trap");
        issue(3'd2, 32'h15, 0, 32'h0, 0, 0, 1, 0, "lh_mis_trap");
        issue(3'd6, 32'h13, 32'h1234, 0, 0, 0, 1, 0, "sh_mis_trap");
`else
        issue(3'd4, 32'h12, 0, 32'h11AB_BEEF, 0, 0, 0, 1, "lw_mis_forced");
        issue(3'd2, 32'h15, 0, 32'hFFFF_CAFE, 0, 0, 0, 1, "lh_mis_forced");
`endif
        chk("mem4_after_mis", mem[4], 32'h11AB_BEEF);

        // Reset during the write cycle of a sub-word store
        req = 1'b1; mem_op = 3'd5; addr = 32'h10; wdata = 32'h0000_0055;
        @(negedge clk);
        chk("rmwrst_c0_stall", {31'b0, stall_req}, 32'h1);
        @(posedge clk); #1;
        chk("rmwrst_we_before", {31'b0, ram_we}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rmwrst_we_drop", {31'b0, ram_we}, 32'h0);
        chk("rmwrst_ce_drop", {31'b0, ram_ce}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        @(negedge clk);
        chk("rmwrst_idle_ce", {31'b0, ram_ce}, 32'h0);
        chk("rmwrst_mem4", mem[4], 32'h11AB_BEEF);
        @(posedge clk); #1;
        issue(3'd4, 32'h10, 0, 32'h11AB_BEEF, 0, 0, 0, 1, "lw_after_rmwrst");

        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
